// File: rtl/lia_startup_seq.sv
// Lock-in datapath startup/reconfiguration sequencer.
// Reset -> source enable -> ready wait -> LPF settle -> run, with sticky fault trap.
module lia_startup_seq #(
    parameter int unsigned RST_CYCLES  = 100,
    parameter int unsigned RDY_TIMEOUT = 100000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_update,
    input  logic [CNT_W-1:0] settle_cycles,
    input  logic             adc_ready,
    input  logic             dds_ready,
    output logic             dp_rst,
    output logic             dds_en,
    output logic             adc_en,
    output logic             lpf_en,
    output logic             lpf_clear,
    output logic             out_valid,
    output logic             busy,
    output logic             fault,
    output logic [2:0]       state
);

    localparam int unsigned TMAX = (RST_CYCLES > RDY_TIMEOUT) ? RST_CYCLES : RDY_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] RDY_LAST = TW'(RDY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_WAIT   = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [CNT_W-1:0] slat_q, slat_d;
    logic             fault_d, clear_d;
    logic             dp_rst_d, src_en_d, lpf_en_d, valid_d, busy_d;
    logic             srcs_ok;

    assign srcs_ok = adc_ready & dds_ready;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        scnt_d  = scnt_q;
        slat_d  = slat_q;
        fault_d = fault;
        clear_d = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            tmr_d   = '0;
            scnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_FAULT: begin
                    if (start) begin
                        state_d = S_RESET;
                        tmr_d   = '0;
                        fault_d = 1'b0;
                    end
                end
                S_RESET: begin
                    if (tmr_q >= RST_LAST) begin
                        state_d = S_WAIT;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                S_WAIT: begin
                    if (srcs_ok) begin
                        state_d = S_SETTLE;
                        slat_d  = settle_cycles;
                        scnt_d  = '0;
                        clear_d = 1'b1;
                    end else if (tmr_q >= RDY_LAST) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                S_SETTLE: begin
                    if (!srcs_ok) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else if (cfg_update) begin
                        slat_d  = settle_cycles;
                        scnt_d  = '0;
                        clear_d = 1'b1;
                    end else if (scnt_q >= slat_q) begin
                        state_d = S_RUN;
                    end else begin
                        scnt_d = scnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // Source loss wins over a simultaneous reconfiguration
                    if (!srcs_ok) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else if (cfg_update) begin
                        state_d = S_SETTLE;
                        slat_d  = settle_cycles;
                        scnt_d  = '0;
                        clear_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                    scnt_d  = '0;
                end
            endcase
        end
        dp_rst_d = (state_d == S_IDLE) || (state_d == S_RESET) || (state_d == S_FAULT);
        src_en_d = (state_d == S_WAIT) || (state_d == S_SETTLE) || (state_d == S_RUN);
        lpf_en_d = (state_d == S_SETTLE) || (state_d == S_RUN);
        valid_d  = (state_d == S_RUN);
        busy_d   = (state_d == S_RESET) || (state_d == S_WAIT) || (state_d == S_SETTLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            scnt_q    <= '0;
            slat_q    <= '0;
            dp_rst    <= 1'b1;
            dds_en    <= 1'b0;
            adc_en    <= 1'b0;
            lpf_en    <= 1'b0;
            lpf_clear <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            scnt_q    <= scnt_d;
            slat_q    <= slat_d;
            dp_rst    <= dp_rst_d;
            dds_en    <= src_en_d;
            adc_en    <= src_en_d;
            lpf_en    <= lpf_en_d;
            lpf_clear <= clear_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            fault     <= fault_d;
        end
    end

    assign state = state_q;

endmodule
